// File: rtl/if_id_pkg.sv
// -----------------------------------------------------------------------------
// if_id_pkg
//   Shared definitions for the IF/ID elastic buffer.
//   - if_id_entry_t : one buffered fetch result {pc, ins} at default widths
//   - IFID_NOP      : bubble instruction (addi x0,x0,0)
//   - ptr_width()   : pointer width for a given entry count (at least 1 bit)
// -----------------------------------------------------------------------------
package if_id_pkg;

  localparam int XLEN_DEF = 32;
  localparam int ILEN_DEF = 32;

  localparam logic [31:0] IFID_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [ILEN_DEF-1:0] ins;
  } if_id_entry_t;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage : if_id_pkg

// File: rtl/if_id_entry_ram.sv
// -----------------------------------------------------------------------------
// if_id_entry_ram
//   DEPTH x WIDTH storage for the IF/ID buffer.
//   Ports:
//     clk      in   write clock
//     wr_en    in   write strobe
//     wr_addr  in   write index
//     wr_data  in   entry to store
//     rd_addr  in   read index (asynchronous read)
//     rd_data  out  entry at rd_addr
// -----------------------------------------------------------------------------
module if_id_entry_ram #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  parameter int AW    = 1
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset; validity is tracked by the occupancy count,
  // so stale contents are never presented and the array maps to plain storage.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule : if_id_entry_ram

// File: rtl/if_id_pipe_buf.sv
// -----------------------------------------------------------------------------
// if_id_pipe_buf
//   DEPTH-entry elastic buffer between fetch and decode. IF pushes on hit while
//   there is space; ID pops the head under valid/ready. Flush empties the
//   buffer synchronously; an empty buffer presents a NOP bubble.
//   Ports:
//     CLK, RESET_N        clock, asynchronous active-low reset
//     next_pc, ins, hit   IF-side entry and valid
//     if_ready            space available (registered state only)
//     flush               synchronous empty (branch/jump redirect)
//     id_ready            ID consumes head this cycle
//     valid_out, ins_out, next_pc_out   head entry (NOP / 0 when empty)
//     count               occupancy
//   Optional build macro IFID_PERF_CNT_EN adds saturating counters
//     stall_cycles, flush_drops (cleared by reset only).
// -----------------------------------------------------------------------------
module if_id_pipe_buf
  import if_id_pkg::*;
#(
  parameter int              XLEN    = 32,
  parameter int              ILEN    = 32,
  parameter int              DEPTH   = 2,
  parameter logic [ILEN-1:0] NOP_INS = ILEN'(IFID_NOP)
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic [XLEN-1:0]          next_pc,
  input  logic [ILEN-1:0]          ins,
  input  logic                     hit,
  output logic                     if_ready,
  input  logic                     flush,
  input  logic                     id_ready,
  output logic                     valid_out,
  output logic [ILEN-1:0]          ins_out,
  output logic [XLEN-1:0]          next_pc_out,
`ifdef IFID_PERF_CNT_EN
  output logic [31:0]              stall_cycles,
  output logic [31:0]              flush_drops,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = XLEN + ILEN;

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;
  logic [EW-1:0] rd_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Handshake terms; if_ready depends only on the registered count.
  assign if_ready  = (count != CW'(DEPTH));
  assign valid_out = (count != '0);
  assign push      = hit & if_ready & ~flush;
  assign pop       = valid_out & id_ready & ~flush;

  if_id_entry_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW),
    .AW    (PW)
  ) u_ram (
    .clk     (CLK),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data ({next_pc, ins}),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values of push/pop and the other pointers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Head presentation; bubble when empty.
  assign ins_out     = valid_out ? rd_data[ILEN-1:0]  : NOP_INS;
  assign next_pc_out = valid_out ? rd_data[EW-1:ILEN] : '0;

`ifdef IFID_PERF_CNT_EN
  logic [32:0] drop_sum;

  // Entries lost on flush: everything buffered, plus the fetch that would
  // otherwise have been accepted this cycle.
  always_comb begin
    drop_sum = {1'b0, flush_drops} + 33'(count) + 33'(hit & if_ready);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      stall_cycles <= '0;
      flush_drops  <= '0;
    end else begin
      if (hit && !if_ready && !flush && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
      if (flush)
        flush_drops <= drop_sum[32] ? '1 : drop_sum[31:0];
    end
  end
`endif

endmodule : if_id_pipe_buf
